util_icap_ctrl: RTL

//  Sequencer in front of the ICAPE2/ICAPE3 wrapper. Streams partial bitstream words from a valid/ready

---
 rtl/util_icap_pkg.sv | 40 ++++
 rtl/util_icap_ctrl_if.sv | 24 ++
 rtl/util_icap_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/util_icap_pkg.sv
// util_icap_pkg: shared types and constants for the ICAP sequencer.
// FSM state type, configuration packet words and byte bit-swap helper.
package util_icap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_CMD,
    RD_TURN,
    RD_WAIT,
    RD_BACK,
    RD_DESYNC
  } state_e;

  localparam logic [31:0] DUMMY       = 32'hFFFF_FFFF;
  localparam logic [31:0] SYNC        = 32'hAA99_5566;
  localparam logic [31:0] NOOP        = 32'h2000_0000;
  localparam logic [31:0] RD_HDR_BASE = 32'h2800_0001;
  localparam logic [31:0] CMD_WR_HDR  = 32'h3000_8001;
  localparam logic [31:0] DESYNC      = 32'h0000_000D;

  // ROM indices of the last command word and last desync word
  localparam logic [3:0] CMD_LAST    = 4'd5;
  localparam logic [3:0] DESYNC_LAST = 4'd9;

  // Reverse bit order inside every byte (ICAP bus bit ordering)
  function automatic logic [31:0] bit_swap(
    input logic [31:0] x
  );
    logic [31:0] y;
    y = '0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        y[8*b+k] = x[8*b+7-k];
      end
    end
    return y;
  endfunction

endpackage

// File: rtl/util_icap_ctrl_if.sv
// util_icap_ctrl_if: valid/ready bitstream word stream into the sequencer.
// master = word source, slave = util_icap_ctrl.
interface util_icap_ctrl_if;

  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_last;
  logic        wr_ready;

  modport master (
    output wr_data,
    output wr_valid,
    output wr_last,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_valid,
    input  wr_last,
    output wr_ready
  );

endinterface

// File: rtl/util_icap_ctrl.sv
// util_icap_ctrl: sequencer in front of the ICAPE2/ICAPE3 wrapper.
// Ports: clk/rst; wr (stream slave); rd_req/rd_addr -> rd_data/rd_done;
// busy, pr_done, sticky error/err_clr; icap_* to/from the wrapper.
// ICAP-side signals are registered: a word accepted or selected in one
// cycle appears on icap_i with csib=0 the following cycle. wr_ready is
// decoded from the state and gated by AVAIL in the same cycle so that a
// word is only taken while ICAP is available.
module util_icap_ctrl
  import util_icap_pkg::*;
#(
  parameter int C_FAMILY_TYPE = 0,
  parameter int C_BIT_SWAP    = 1,
  parameter int C_READ_WAIT   = 3
) (
  input  logic            clk,
  input  logic            rst,
  util_icap_ctrl_if.slave wr,
  input  logic            rd_req,
  input  logic [4:0]      rd_addr,
  output logic [31:0]     rd_data,
  output logic            rd_done,
  output logic            busy,
  output logic            pr_done,
  output logic            error,
  input  logic            err_clr,
  output logic            icap_csib,
  output logic            icap_rdwrb,
  output logic [31:0]     icap_i,
  input  logic [31:0]     icap_o,
  input  logic            icap_avail,
  input  logic            icap_prdone,
  input  logic            icap_prerror
);

  localparam bit FAM_US = (C_FAMILY_TYPE != 0);
  localparam logic [3:0] WAIT_TC = 4'(C_READ_WAIT);

  function automatic logic [31:0] swz(
    input logic [31:0] x
  );
    return (C_BIT_SWAP != 0) ? bit_swap(x) : x;
  endfunction

  function automatic logic [31:0] seq_rom(
    input logic [3:0] i,
    input logic [4:0] a
  );
    logic [31:0] w;
    case (i)
      4'd0:    w = DUMMY;
      4'd1:    w = SYNC;
      4'd3:    w = RD_HDR_BASE | {14'd0, a, 13'd0};
      4'd6:    w = CMD_WR_HDR;
      4'd7:    w = DESYNC;
      default: w = NOOP;
    endcase
    return w;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  addr_q, addr_d;
  logic        csib_q, csib_d;
  logic        rdwrb_q, rdwrb_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdat_q, rdat_d;
  logic        done_q, done_d;
  logic        prd_q, prd_d;
  logic        prp_q, prp_d;
  logic        err_q, err_d;

  logic av;
  logic acc;

  assign av  = FAM_US ? icap_avail : 1'b1;
  assign acc = wr.wr_valid && wr.wr_ready;

  assign wr.wr_ready = (state_q == WR) && av;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    csib_d  = 1'b1;
    rdwrb_d = 1'b0;
    word_d  = word_q;
    rdat_d  = rdat_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (rd_req) begin
          addr_d  = rd_addr;
          state_d = RD_CMD;
        end else if (wr.wr_valid) begin
          state_d = WR;
        end
      end
      WR: begin
        if (acc) begin
          csib_d = 1'b0;
          word_d = swz(wr.wr_data);
          if (wr.wr_last) state_d = IDLE;
        end
      end
      RD_CMD: begin
        if (av) begin
          csib_d = 1'b0;
          word_d = swz(seq_rom(idx_q, addr_q));
          idx_d  = idx_q + 4'd1;
          if (idx_q == CMD_LAST) state_d = RD_TURN;
        end
      end
      RD_TURN: begin
        // deselect while flipping to read so RDWRB never moves under csib=0
        rdwrb_d = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        csib_d  = 1'b0;
        rdwrb_d = 1'b1;
        if (av) begin
          if (cnt_q == WAIT_TC) begin
            rdat_d  = swz(icap_o);
            csib_d  = 1'b1;
            state_d = RD_BACK;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      RD_BACK: begin
        state_d = RD_DESYNC;
      end
      RD_DESYNC: begin
        if (av) begin
          csib_d = 1'b0;
          word_d = swz(seq_rom(idx_q, addr_q));
          idx_d  = idx_q + 4'd1;
          if (idx_q == DESYNC_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prd_d = FAM_US && icap_prdone;
    prp_d = FAM_US && icap_prdone && !prd_q;
    err_d = err_q;
    if (FAM_US && icap_prerror) err_d = 1'b1;
    else if (err_clr)           err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      csib_q  <= 1'b1;
      rdwrb_q <= 1'b0;
      word_q  <= '0;
      rdat_q  <= '0;
      done_q  <= 1'b0;
      prd_q   <= 1'b0;
      prp_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      csib_q  <= csib_d;
      rdwrb_q <= rdwrb_d;
      word_q  <= word_d;
      rdat_q  <= rdat_d;
      done_q  <= done_d;
      prd_q   <= prd_d;
      prp_q   <= prp_d;
      err_q   <= err_d;
    end
  end

  assign icap_csib  = csib_q;
  assign icap_rdwrb = rdwrb_q;
  assign icap_i     = word_q;
  assign rd_data    = rdat_q;
  assign rd_done    = done_q;
  assign busy       = (state_q != IDLE);
  assign pr_done    = prp_q;
  assign error      = err_q;

endmodule
